// File: rtl/game_pkg.sv
// Shared constants for the memory-sequence game: position width, move timeout and the fixed sequence.
package game_pkg;

    localparam int POS_W              = 4;
    localparam int TIMEOUT_CYCLES_DEF = 5000;

    // One-hot button pattern expected at each play position.
    localparam logic [3:0] ROM_SEQ [16] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
        4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4
    };

endpackage

// File: rtl/contador_m.sv
// Modulo-M up-counter with clear (zera) over count (conta); fim flags the last value.
// One cycle from strobe to new count; SAT=1 holds at M-1 instead of wrapping.
module contador_m #(
    parameter int M   = 16,
    parameter int W   = 4,
    parameter bit SAT = 1'b0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         zera,
    input  logic         conta,
    output logic [W-1:0] q,
    output logic         fim
);

    localparam logic [W-1:0] LAST = W'(M - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (zera) begin
            cnt_d = '0;
        end else if (conta) begin
            if (cnt_q == LAST) begin
                cnt_d = SAT ? LAST : '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q   = cnt_q;
    assign fim = (cnt_q == LAST);

endmodule

// File: rtl/exp5_fluxo_dados.sv
// Game datapath: position/limit counters, button register, sequence ROM, press edge detector, move timeout.
// Strobe-driven with no backpressure; state updates one cycle after a strobe, flags are combinational from state.
module exp5_fluxo_dados
    import game_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int TW             = 13
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             zeraE,
    input  logic             contaE,
    input  logic             zeraL,
    input  logic             contaL,
    input  logic             zeraR,
    input  logic             registraR,
    input  logic             contaT,
    input  logic [3:0]       botoes,
    output logic             fimE,
    output logic             fimL,
    output logic             igualE,
    output logic             igualL,
    output logic             jogada,
    output logic             timeout,
    output logic [POS_W-1:0] db_contagem,
    output logic [POS_W-1:0] db_limite,
    output logic [3:0]       db_memoria,
    output logic [3:0]       db_jogada
);

    logic [POS_W-1:0] e_cnt, l_cnt;
    logic [3:0]       r_q, r_d;
    logic             prev_q;
    logic [3:0]       mem;
    logic [TW-1:0]    t_cnt_unused;
    logic             t_fim;

    contador_m #(.M(16), .W(POS_W), .SAT(1'b0)) u_cnt_e (
        .clock (clock),
        .reset (reset),
        .zera  (zeraE),
        .conta (contaE),
        .q     (e_cnt),
        .fim   (fimE)
    );

    contador_m #(.M(16), .W(POS_W), .SAT(1'b0)) u_cnt_l (
        .clock (clock),
        .reset (reset),
        .zera  (zeraL),
        .conta (contaL),
        .q     (l_cnt),
        .fim   (fimL)
    );

    // Held in reset whenever contaT is low, so every idle cycle restarts the move timer.
    contador_m #(.M(TIMEOUT_CYCLES), .W(TW), .SAT(1'b1)) u_cnt_t (
        .clock (clock),
        .reset (reset),
        .zera  (~contaT),
        .conta (contaT),
        .q     (t_cnt_unused),
        .fim   (t_fim)
    );

    always_comb begin
        r_d = r_q;
        if (zeraR) begin
            r_d = '0;
        end else if (registraR) begin
            r_d = botoes;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q    <= '0;
            prev_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            prev_q <= |botoes;
        end
    end

    always_comb begin
        mem = ROM_SEQ[0];
        case (e_cnt)
            4'd0:  mem = ROM_SEQ[0];
            4'd1:  mem = ROM_SEQ[1];
            4'd2:  mem = ROM_SEQ[2];
            4'd3:  mem = ROM_SEQ[3];
            4'd4:  mem = ROM_SEQ[4];
            4'd5:  mem = ROM_SEQ[5];
            4'd6:  mem = ROM_SEQ[6];
            4'd7:  mem = ROM_SEQ[7];
            4'd8:  mem = ROM_SEQ[8];
            4'd9:  mem = ROM_SEQ[9];
            4'd10: mem = ROM_SEQ[10];
            4'd11: mem = ROM_SEQ[11];
            4'd12: mem = ROM_SEQ[12];
            4'd13: mem = ROM_SEQ[13];
            4'd14: mem = ROM_SEQ[14];
            4'd15: mem = ROM_SEQ[15];
            default: mem = ROM_SEQ[0];
        endcase
    end

    assign igualE      = (mem == r_q);
    assign igualL      = (e_cnt == l_cnt);
    assign jogada      = (|botoes) & ~prev_q;
    assign timeout     = contaT & t_fim;
    assign db_contagem = e_cnt;
    assign db_limite   = l_cnt;
    assign db_memoria  = mem;
    assign db_jogada   = r_q;

endmodule

// File: tb/tb_exp5_fluxo_dados.sv
// Directed bench for exp5_fluxo_dados: a cycle-by-cycle vector table plus hand sequences for wrap, edges and timeout.
module tb_exp5_fluxo_dados;

    logic       clock = 1'b0;
    logic       reset;
    logic       zeraE, contaE, zeraL, contaL, zeraR, registraR, contaT;
    logic [3:0] botoes;
    logic       fimE, fimL, igualE, igualL, jogada, timeout;
    logic [3:0] db_contagem, db_limite, db_memoria, db_jogada;

    always #5 clock = ~clock;

    exp5_fluxo_dados #(.TIMEOUT_CYCLES(10), .TW(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .zeraE       (zeraE),
        .contaE      (contaE),
        .zeraL       (zeraL),
        .contaL      (contaL),
        .zeraR       (zeraR),
        .registraR   (registraR),
        .contaT      (contaT),
        .botoes      (botoes),
        .fimE        (fimE),
        .fimL        (fimL),
        .igualE      (igualE),
        .igualL      (igualL),
        .jogada      (jogada),
        .timeout     (timeout),
        .db_contagem (db_contagem),
        .db_limite   (db_limite),
        .db_memoria  (db_memoria),
        .db_jogada   (db_jogada)
    );

    int n_vec = 0;
    int n_bad = 0;

    // ctl = {zeraE, contaE, zeraL, contaL, zeraR, registraR, contaT}
    // exp = {E, L, R, ROM[E], fimE, fimL, igualE, igualL, jogada, timeout}
    typedef struct {
        logic [6:0]  ctl;
        logic [3:0]  b;
        logic [21:0] exp;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic [6:0] c, input logic [3:0] b,
                                input logic [3:0] e, input logic [3:0] l,
                                input logic [3:0] r, input logic [3:0] m,
                                input logic [5:0] f);
        vec_t v;
        v.ctl = c;
        v.b   = b;
        v.exp = {e, l, r, m, f};
        return v;
    endfunction

    function automatic logic [21:0] obs();
        return {db_contagem, db_limite, db_jogada, db_memoria,
                fimE, fimL, igualE, igualL, jogada, timeout};
    endfunction

    task automatic drive(input logic [6:0] c, input logic [3:0] b);
        {zeraE, contaE, zeraL, contaL, zeraR, registraR, contaT} = c;
        botoes = b;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    localparam logic [6:0] C_IDLE = 7'b0000000;
    localparam logic [6:0] C_ZE   = 7'b1000000;
    localparam logic [6:0] C_CE   = 7'b0100000;
    localparam logic [6:0] C_ZL   = 7'b0010000;
    localparam logic [6:0] C_CL   = 7'b0001000;
    localparam logic [6:0] C_ZR   = 7'b0000100;
    localparam logic [6:0] C_RR   = 7'b0000010;
    localparam logic [6:0] C_CT   = 7'b0000001;

    int cnt;
    int first_at;

    initial begin
        tbl[0]  = mk(C_IDLE,      4'h0, 4'd0, 4'd0, 4'h0, 4'h1, 6'b000100);
        tbl[1]  = mk(C_CE,        4'h0, 4'd0, 4'd0, 4'h0, 4'h1, 6'b000100);
        tbl[2]  = mk(C_CE,        4'h0, 4'd1, 4'd0, 4'h0, 4'h2, 6'b000000);
        tbl[3]  = mk(C_RR,        4'h4, 4'd2, 4'd0, 4'h0, 4'h4, 6'b000010);
        tbl[4]  = mk(C_IDLE,      4'h0, 4'd2, 4'd0, 4'h4, 4'h4, 6'b001000);
        tbl[5]  = mk(C_RR,        4'h1, 4'd2, 4'd0, 4'h4, 4'h4, 6'b001010);
        tbl[6]  = mk(C_IDLE,      4'h0, 4'd2, 4'd0, 4'h1, 4'h4, 6'b000000);
        tbl[7]  = mk(C_ZE | C_CE, 4'h0, 4'd2, 4'd0, 4'h1, 4'h4, 6'b000000);
        tbl[8]  = mk(C_CL,        4'h0, 4'd0, 4'd0, 4'h1, 4'h1, 6'b001100);
        tbl[9]  = mk(C_CL,        4'h0, 4'd0, 4'd1, 4'h1, 4'h1, 6'b001000);
        tbl[10] = mk(C_CL | C_CE, 4'h0, 4'd0, 4'd2, 4'h1, 4'h1, 6'b001000);
        tbl[11] = mk(C_CE,        4'h0, 4'd1, 4'd3, 4'h1, 4'h2, 6'b000000);
        tbl[12] = mk(C_CE,        4'h0, 4'd2, 4'd3, 4'h1, 4'h4, 6'b000000);
        tbl[13] = mk(C_CE,        4'h0, 4'd3, 4'd3, 4'h1, 4'h8, 6'b000100);
        tbl[14] = mk(C_ZR | C_RR, 4'h2, 4'd4, 4'd3, 4'h1, 4'h4, 6'b000010);
        tbl[15] = mk(C_ZL | C_CL, 4'h0, 4'd4, 4'd3, 4'h0, 4'h4, 6'b000000);
        tbl[16] = mk(C_ZE,        4'h0, 4'd4, 4'd0, 4'h0, 4'h4, 6'b000000);
        tbl[17] = mk(C_IDLE,      4'h0, 4'd0, 4'd0, 4'h0, 4'h1, 6'b000100);

        drive(C_IDLE, 4'h0);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1 chk("reset_state", 32'(obs()), 32'({4'd0, 4'd0, 4'h0, 4'h1, 6'b000100}));

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].ctl, tbl[i].b);
            #1 chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
            @(negedge clock);
        end

        // E and L both to 15, then wrap E
        for (int i = 0; i < 15; i++) begin
            drive(C_CE | C_CL, 4'h0);
            @(negedge clock);
        end
        drive(C_IDLE, 4'h0);
        #1;
        chk("wrap_E15",   32'(db_contagem), 32'd15);
        chk("wrap_fimE",  32'(fimE),        32'd1);
        chk("wrap_rom15", 32'(db_memoria),  32'h4);
        chk("wrap_fimL",  32'(fimL),        32'd1);
        chk("wrap_igualL", 32'(igualL),     32'd1);
        @(negedge clock);
        drive(C_CE, 4'h0);
        @(negedge clock);
        drive(C_IDLE, 4'h0);
        #1;
        chk("wrap_E0",     32'(db_contagem), 32'd0);
        chk("wrap_fimE0",  32'(fimE),        32'd0);
        chk("wrap_igualL0", 32'(igualL),     32'd0);
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            drive(C_CE, 4'h0);
            @(negedge clock);
        end
        drive(C_ZE | C_CE, 4'h0);
        @(negedge clock);
        drive(C_ZL, 4'h0);
        #1 chk("zeraE_wins", 32'(db_contagem), 32'd0);
        @(negedge clock);
        drive(C_IDLE, 4'h0);
        @(negedge clock);

        // long press: one pulse, on the rising cycle
        cnt = 0;
        first_at = -1;
        for (int i = 0; i < 10; i++) begin
            drive(C_IDLE, 4'h8);
            #1;
            if (jogada) begin
                cnt++;
                if (first_at < 0) first_at = i;
            end
            @(negedge clock);
        end
        chk("edge_count1", 32'(cnt), 32'd1);
        chk("edge_first",  32'(first_at), 32'd0);
        drive(C_IDLE, 4'h0);
        @(negedge clock);
        @(negedge clock);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive(C_IDLE, 4'h8);
            #1;
            if (jogada) cnt++;
            @(negedge clock);
        end
        chk("edge_count2", 32'(cnt), 32'd1);

        // button held through reset pulses right after reset
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1 chk("held_reset_pulse", 32'(jogada), 32'd1);
        @(negedge clock);
        #1 chk("held_reset_once", 32'(jogada), 32'd0);
        drive(C_IDLE, 4'h0);
        @(negedge clock);

        for (int k = 1; k <= 12; k++) begin
            drive(C_CT, (k == 11) ? 4'h8 : 4'h0);
            #1 chk($sformatf("timeout_k%0d", k), 32'(timeout), (k >= 10) ? 32'd1 : 32'd0);
            if (k == 11) chk("timeout_with_jogada", 32'(jogada), 32'd1);
            @(negedge clock);
        end
        drive(C_IDLE, 4'h0);
        #1 chk("timeout_dropped", 32'(timeout), 32'd0);
        @(negedge clock);
        for (int k = 1; k <= 10; k++) begin
            drive(C_CT, 4'h0);
            #1 chk($sformatf("timeout_re_k%0d", k), 32'(timeout), (k == 10) ? 32'd1 : 32'd0);
            @(negedge clock);
        end
        drive(C_IDLE, 4'h0);
        @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/exp5_fluxo_dados.md
Name: exp5_fluxo_dados

Overview:
- Datapath for the memory-sequence game. Sits directly under the game control unit, which drives its control strobes and consumes its status flags.
- Holds three state elements: the play-position counter E, the round-limit counter L, and the button register R.
- Holds the 16x4 sequence ROM, the button edge detector and the per-move timeout counter.
- Status flags: fimE, fimL, igualE, igualL, jogada, timeout.

Parameters:
- TIMEOUT_CYCLES, 5000: clock cycles allowed per move (5 s at 1 kHz).
- TW, 13: width of the timeout counter; must satisfy 2^TW >= TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- zeraE  in  1  clear counter E
- contaE  in  1  increment counter E
- zeraL  in  1  clear counter L
- contaL  in  1  increment counter L
- zeraR  in  1  clear register R
- registraR  in  1  load botoes into R
- contaT  in  1  timeout counter runs while high
- botoes  in  4  player buttons, one-hot when pressed, already synchronised
- fimE  out  1  E == 15
- fimL  out  1  L == 15
- igualE  out  1  ROM[E] == R
- igualL  out  1  E == L
- jogada  out  1  one-cycle pulse on a button press
- timeout  out  1  move time expired
- db_contagem  out  4  E
- db_limite  out  4  L
- db_memoria  out  4  ROM[E]
- db_jogada  out  4  R

Behaviour:
- Reset: only clock and reset are fixed. Reset is synchronous and active-high: when reset is high at a rising clock edge, E, L, R, the timeout counter and the edge-detect register all become 0.
- Post-reset outputs:
  - fimE=0, fimL=0, igualL=1 (E=L=0), jogada=0, timeout=0.
  - igualE = (ROM[0] == 0) = 0.
- Counter E (4 bit): priority is reset > zeraE > contaE > hold. At 15, contaE wraps to 0. zeraE and contaE together: zeraE wins.
- Counter L (4 bit): same rules, using zeraL/contaL.
- Register R (4 bit): priority is reset > zeraR > registraR > hold. Loads botoes on the edge where registraR is high. The new R is visible the next cycle, so igualE is valid in the cycle after registraR.
- ROM: combinational read addressed by E, so db_memoria and igualE follow E with no latency.
- ROM contents, addresses 0..15:
  1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4 (hex, 4-bit one-hot).
- Comparators: fimE, fimL, igualE and igualL are purely combinational from the registered values.
- Edge detector:
  - prev <= |botoes every cycle.
  - jogada = (|botoes) & ~prev: high for exactly one cycle per press, however long the button is held.
  - A press already held through reset produces a pulse in the first cycle after reset, because prev is cleared.
- Timeout counter (TW bit):
  - contaT=0: counter cleared to 0.
  - contaT=1: counter increments, saturating at TIMEOUT_CYCLES-1.
  - timeout = contaT & (count == TIMEOUT_CYCLES-1), combinational.
  - timeout is first high on the TIMEOUT_CYCLES-th consecutive cycle with contaT=1.
  - Any cycle with contaT=0 restarts the count.
- Simultaneous jogada and timeout are both presented; the control unit resolves priority (timeout wins).
- No internal FSM: the block is a strobe-driven datapath with counters and registers.

Decomposition:
- Shared package game_pkg:
  - ROM sequence constant array (16 x 4-bit).
  - Position width constant (4).
  - Default TIMEOUT_CYCLES.
- Sub-modules:
  - One natural sub-module: contador_m, a generic modulo-M up-counter with zera and conta inputs and a fim output. Instantiate it three times: E (M=16), L (M=16), and timeout (M=TIMEOUT_CYCLES, saturating variant selected by parameter).
  - The ROM stays inline as a case on E.

Test Plan:
- Reset check: assert reset for 2 cycles with botoes=0 -> db_contagem=0, db_limite=0, db_jogada=0, igualL=1, fimE=0, jogada=0, timeout=0.
- Counter wrap: pulse contaE 15 times -> fimE=1, db_memoria=4. One more contaE -> E=0, fimE=0. zeraE with contaE together -> E=0.
- Compare: E=2 (ROM=4), botoes=4 with registraR=1 -> next cycle db_jogada=4, igualE=1. Load botoes=1 -> igualE=0.
- Limit: contaL 3 times, contaE 3 times -> igualL=1. One more contaE -> igualL=0, fimL=0.
- Edge detector: hold botoes=8 for 10 cycles -> jogada high exactly 1 cycle, in the cycle botoes rises. Release then press again -> a second single-cycle pulse.
- Timeout (TIMEOUT_CYCLES=10 override): contaT=1 continuously -> timeout=0 for cycles 1..9, then 1 from cycle 10 on. Drop contaT for 1 cycle, then reassert -> timeout is next high 10 cycles later.
